// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: opcode constant and the saturating-counter helpers.
package bp_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Helpers work on a wide carrier; callers truncate to their own CNT_BITS.
  localparam int CNT_W_MAX = 16;
  typedef logic [CNT_W_MAX-1:0] cnt_t;

  // Weakly-not-taken: MSB clear, every lower bit set.
  function automatic cnt_t cnt_wnt(input int unsigned bits);
    return (cnt_t'(1) << (bits - 1)) - cnt_t'(1);
  endfunction

  function automatic cnt_t cnt_sat(input cnt_t c, input logic up, input int unsigned bits);
    cnt_t max_v;
    max_v = (cnt_t'(1) << bits) - cnt_t'(1);
    if (up) return (c == max_v) ? c : c + cnt_t'(1);
    else    return (c == '0)    ? c : c - cnt_t'(1);
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: one saturating counter per entry, one read and one write port.
module bp_pht
  import bp_pkg::*;
#(
  parameter int N_ENTRIES = 16,
  parameter int CNT_BITS  = 2,
  localparam int IDX_BITS = $clog2(N_ENTRIES)
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_msb,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_taken
);

  localparam logic [CNT_BITS-1:0] WNT = CNT_BITS'(cnt_wnt(CNT_BITS));

  logic [N_ENTRIES-1:0][CNT_BITS-1:0] cnt_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)
      cnt_q <= {N_ENTRIES{WNT}};
    else if (wr_en)
      cnt_q[wr_idx] <= CNT_BITS'(cnt_sat(cnt_t'(cnt_q[wr_idx]), wr_taken, CNT_BITS));
  end

  assign rd_msb = cnt_q[rd_idx][CNT_BITS-1];

endmodule

// File: rtl/branch_predictor_btb.sv
// IF-stage branch predictor: tagged BTB for targets, bimodal/gshare PHT for direction.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int N_ENTRIES = 16,
  parameter int IDX_LO    = 2,
  parameter int TAG_BITS  = 8,
  parameter int CNT_BITS  = 2,
  parameter int GHR_BITS  = 0,
  localparam int IDX_BITS = $clog2(N_ENTRIES),
  localparam int GW       = (GHR_BITS > 0) ? GHR_BITS : 1
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic [GW-1:0]   pred_ghr,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic [GW-1:0]   upd_ghr,
  input  logic            flush
);

  localparam int TAG_LO = IDX_LO + IDX_BITS;

  logic [N_ENTRIES-1:0]               valid_q;
  logic [N_ENTRIES-1:0][TAG_BITS-1:0] tag_q;
  logic [N_ENTRIES-1:0][XLEN-1:0]     tgt_q;
  logic [GW-1:0]                      ghr_q;

  logic [IDX_BITS-1:0] btb_idx, upd_idx, pht_rd_idx, pht_wr_idx, upd_hx;
  logic [TAG_BITS-1:0] if_tag, upd_tag;
  logic                pht_msb, upd_en;

  assign btb_idx = if_pc[IDX_LO +: IDX_BITS];
  assign if_tag  = if_pc[TAG_LO +: TAG_BITS];
  assign upd_idx = upd_pc[IDX_LO +: IDX_BITS];
  assign upd_tag = upd_pc[TAG_LO +: TAG_BITS];
  assign upd_en  = upd_valid & ~flush;

  // ghr_q is tied to zero in bimodal mode, so only the update side needs masking.
  assign upd_hx     = (GHR_BITS > 0) ? IDX_BITS'(upd_ghr) : '0;
  assign pht_rd_idx = btb_idx ^ IDX_BITS'(ghr_q);
  assign pht_wr_idx = upd_idx ^ upd_hx;

  bp_pht #(.N_ENTRIES(N_ENTRIES), .CNT_BITS(CNT_BITS)) u_pht (
    .clk      (clk),
    .arst_n   (arst_n),
    .rd_idx   (pht_rd_idx),
    .rd_msb   (pht_msb),
    .wr_en    (upd_en),
    .wr_idx   (pht_wr_idx),
    .wr_taken (upd_taken)
  );

  // Only taken branches allocate; a not-taken resolve never touches the BTB.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid_q <= '0;
      tag_q   <= '0;
      tgt_q   <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (upd_valid && upd_taken) begin
      valid_q[upd_idx] <= 1'b1;
      tag_q[upd_idx]   <= upd_tag;
      tgt_q[upd_idx]   <= upd_target;
    end
  end

  generate
    if (GHR_BITS > 0) begin : g_ghr
      // History is rebuilt from the fetch-time snapshot, which undoes wrong-path shifts.
      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)        ghr_q <= '0;
        else if (flush)     ghr_q <= '0;
        else if (upd_valid) ghr_q <= GW'({upd_ghr, upd_taken});
      end
    end else begin : g_no_ghr
      assign ghr_q = '0;
    end
  endgenerate

  assign pred_hit    = valid_q[btb_idx] && (tag_q[btb_idx] == if_tag);
  assign pred_taken  = pred_hit & pht_msb;
  assign pred_target = pred_hit ? tgt_q[btb_idx] : '0;
  assign pred_ghr    = ghr_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^if_pc ^ ^upd_pc;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench: a bimodal and a 2-bit gshare instance driven from shared update lines.
module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [63:0] if_pc, upd_pc, upd_target;
  logic        upd_valid, upd_taken, flush;
  logic        upd_ghr1;
  logic [1:0]  upd_ghr2;

  logic        hit_b, tk_b, hit_g, tk_g;
  logic [63:0] tgt_b, tgt_g;
  logic        ghr_b;
  logic [1:0]  ghr_g;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predictor_btb dut (
    .clk(clk), .arst_n(arst_n), .if_pc(if_pc),
    .pred_hit(hit_b), .pred_taken(tk_b), .pred_target(tgt_b), .pred_ghr(ghr_b),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_ghr(upd_ghr1), .flush(flush)
  );

  branch_predictor_btb #(.GHR_BITS(2)) dut_g (
    .clk(clk), .arst_n(arst_n), .if_pc(if_pc),
    .pred_hit(hit_g), .pred_taken(tk_g), .pred_target(tgt_g), .pred_ghr(ghr_g),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_ghr(upd_ghr2), .flush(flush)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [63:0] pc);
    if_pc = pc;
    #1;
  endtask

  task automatic upd(input logic [63:0] pc, input logic tk, input logic [63:0] tgt,
                     input logic [1:0] gh);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_ghr2 = gh;
    tick();
    upd_valid = 1'b0;
  endtask

  // Expected pred_taken after each of 4 taken then 4 not-taken updates at 0x100.
  // Counter: 01->10->11->11->11 then 11->10->01->00->00.
  logic exp_tk_seq [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    arst_n = 1'b0; if_pc = 64'h100; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_ghr1 = 1'b0; upd_ghr2 = '0; flush = 1'b0;
    #12;
    chk("rst_hit", hit_b, 0);
    chk("rst_taken", tk_b, 0);
    chk("rst_target", tgt_b, 0);
    chk("rst_ghr", ghr_b, 0);
    chk("rst_ghr_g", ghr_g, 0);
    arst_n = 1'b1;
    tick();

    // Bimodal training and saturation at both ends
    for (int i = 0; i < 8; i++) begin
      upd(64'h100, i < 4, 64'h80, 2'b00);
      look(64'h100);
      chk($sformatf("train_hit%0d", i), hit_b, 1);
      chk($sformatf("train_taken%0d", i), tk_b, exp_tk_seq[i]);
      chk($sformatf("train_tgt%0d", i), tgt_b, 64'h80);
    end
    look(64'h104);
    chk("neighbour_hit", hit_b, 0);

    // Same-cycle lookup/update: counter 00 -> 01 -> 10, target 0x80 -> 0x90
    if_pc = 64'h100; upd_valid = 1'b1; upd_pc = 64'h100; upd_taken = 1'b1;
    upd_target = 64'h90; upd_ghr2 = '0;
    #1;
    chk("same_old_tgt", tgt_b, 64'h80);
    chk("same_old_taken", tk_b, 0);
    tick();
    chk("same_new_tgt", tgt_b, 64'h90);
    chk("same_mid_taken", tk_b, 0);
    tick();
    upd_valid = 1'b0;
    #1;
    chk("same_new_taken", tk_b, 1);

    // Tag aliasing at index 0 (counter 10 -> 11)
    upd(64'h500, 1'b1, 64'h200, 2'b00);
    look(64'h100);
    chk("alias_old_hit", hit_b, 0);
    chk("alias_old_tgt", tgt_b, 0);
    chk("alias_old_taken", tk_b, 0);
    look(64'h500);
    chk("alias_new_hit", hit_b, 1);
    chk("alias_new_tgt", tgt_b, 64'h200);
    chk("alias_new_taken", tk_b, 1);

    // Not-taken miss: no allocation, counter idx1 01 -> 00 (seen via later allocation)
    upd(64'h204, 1'b0, 64'h300, 2'b00);
    look(64'h204);
    chk("nt_noalloc_hit", hit_b, 0);
    upd(64'h204, 1'b1, 64'h300, 2'b00);
    look(64'h204);
    chk("nt_alloc_hit", hit_b, 1);
    chk("nt_alloc_tgt", tgt_b, 64'h300);
    chk("nt_cnt_low", tk_b, 0);
    upd(64'h204, 1'b1, 64'h300, 2'b00);
    look(64'h204);
    chk("nt_cnt_up", tk_b, 1);

    // Gshare: PHT idx0=11, idx1=10 from the shared updates above
    flush = 1'b1; tick(); flush = 1'b0;
    #1;
    chk("g_flush_ghr", ghr_g, 0);
    upd(64'h100, 1'b1, 64'h80, 2'b01);
    look(64'h100);
    chk("g_ghr_shift", ghr_g, 2'b11);
    chk("g_hit", hit_g, 1);
    chk("g_tgt", tgt_g, 64'h80);
    chk("g_taken_idx3", tk_g, 0);
    chk("b_ghr_zero", ghr_b, 0);

    // Flush wins over a concurrent update
    flush = 1'b1;
    upd(64'h10C, 1'b1, 64'h999, 2'b00);
    flush = 1'b0;
    look(64'h100);
    chk("fl_ghr", ghr_g, 0);
    chk("fl_hit_100", hit_g, 0);
    chk("fl_hit_100_b", hit_b, 0);
    look(64'h10C);
    chk("fl_drop_alloc", hit_g, 0);

    // Re-allocate: writes PHT idx2, GHR -> 01, lookup reads retained idx1=11
    upd(64'h100, 1'b1, 64'h88, 2'b10);
    look(64'h100);
    chk("re_ghr", ghr_g, 2'b01);
    chk("re_hit", hit_g, 1);
    chk("re_tgt", tgt_g, 64'h88);
    chk("re_taken", tk_g, 1);
    chk("re_hit_b", hit_b, 1);

    // Asynchronous reset mid-cycle
    #2;
    arst_n = 1'b0;
    #1;
    chk("arst_hit_b", hit_b, 0);
    chk("arst_hit_g", hit_g, 0);
    chk("arst_ghr_g", ghr_g, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
Parametrised branch predictor for the IF stage. A tagged branch target buffer (BTB) supplies the target address. A separate pattern history table (PHT) of saturating counters supplies the direction, indexed either by PC alone (bimodal) or by PC XOR global history (gshare). Lookup is combinational on the fetch PC. Updates arrive from the branch-resolve stage, carrying the history snapshot taken at prediction time.

Parameters:
XLEN, 64, PC/target width
N_ENTRIES, 16, BTB and PHT depth; power of two, >=2
IDX_LO, 2, lowest PC bit used for the index (4-byte instructions)
TAG_BITS, 8, BTB tag width; tag = pc[IDX_LO+IDX_BITS +: TAG_BITS]
CNT_BITS, 2, PHT counter width, >=2
GHR_BITS, 0, global history length; 0 = bimodal, else 1..IDX_BITS
(localparam IDX_BITS = clog2(N_ENTRIES); GW = max(GHR_BITS,1))

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
if_pc  in  XLEN  fetch PC to predict
pred_hit  out  1  BTB valid and tag match for if_pc
pred_taken  out  1  predict taken (pred_hit & counter MSB)
pred_target  out  XLEN  predicted target; 0 when !pred_hit
pred_ghr  out  GW  GHR value used for this lookup, carried down the pipe
upd_valid  in  1  a conditional branch resolved this cycle
upd_pc  in  XLEN  PC of the resolved branch
upd_taken  in  1  actual outcome
upd_target  in  XLEN  actual taken target
upd_ghr  in  GW  pred_ghr captured when upd_pc was fetched
flush  in  1  invalidate all BTB entries and clear GHR

Behaviour:
- Reset (async, arst_n=0): all BTB valid bits = 0; tags/targets = 0; every PHT counter = weakly-not-taken (0 followed by CNT_BITS-1 ones, i.e. 01 for 2 bits); GHR = 0. Outputs therefore read pred_hit=0, pred_taken=0, pred_target=0, pred_ghr=0.
- Lookup, combinational, zero latency:
  - btb_idx = if_pc[IDX_LO +: IDX_BITS].
  - pht_idx = btb_idx XOR zero-extended GHR; with GHR_BITS=0, pht_idx = btb_idx.
  - pred_hit = valid[btb_idx] & (tag[btb_idx] == if_pc tag field).
- Update, on the clock edge when upd_valid=1 and flush=0:
  - PHT at (upd_pc index XOR upd_ghr) saturates up if upd_taken, down otherwise. No wrap at 0 or at all-ones.
  - BTB at the upd_pc index, taken branch: write valid=1, tag, and target=upd_target. Allocation on a miss replaces any existing entry.
  - BTB, not-taken branch: the entry is unchanged. A miss is not allocated.
  - GHR (GHR_BITS>0): GHR <= {upd_ghr[GHR_BITS-2:0], upd_taken}. Rebuilding from the snapshot repairs history after wrong-path updates.
- Same-cycle lookup and update of the same entry: the lookup sees pre-update state. There is no bypass.
- flush=1: all valid bits cleared and GHR=0 at the next edge. PHT counters, tags and targets are retained. A concurrent upd_valid is discarded entirely.
- Reset asserted mid-operation overrides everything immediately, asynchronously.
- Only the indexed entry changes per cycle; all other entries hold.

Decomposition:
- Shared package bp_pkg holds:
  - OPC_BRANCH = 7'b1100011.
  - A function returning the weakly-not-taken counter value for a given CNT_BITS.
  - A function computing the saturating increment/decrement.
- One natural sub-module: bp_pht. It owns the counter array, the reset initialisation and the saturating update, and exposes a read index/MSB and a write index/taken/enable. The BTB arrays and GHR stay in the top level.

Test Plan:
1. After reset, if_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0, pred_ghr=0.
2. Bimodal (default params): three taken updates at upd_pc=0x100, target 0x80 -> lookup 0x100 gives hit=1, target=0x80, counter sequence 01->10->11->11, pred_taken=1 after the first update. Then three not-taken updates -> 11->10->01->00, pred_taken=0 from the second, hit stays 1.
3. Tag aliasing: train 0x100 (taken, target 0x80), then a taken update at 0x500 (same index, different tag, target 0x200) -> lookup 0x100 gives hit=0; lookup 0x500 gives target 0x200.
4. A not-taken update to the unallocated 0x204 -> lookup 0x204 gives hit=0, and the PHT counter at index 1 is 00.
5. Same-cycle lookup and update of 0x100 -> outputs in that cycle show the old values; the next cycle shows the new ones.
6. GHR_BITS=2: taken updates with upd_ghr=2'b01 -> GHR becomes 2'b11. flush with simultaneous upd_valid -> GHR=0, all hits=0, and a re-allocate after the flush hits with the retained counter.
